// File: rtl/matrix_coproc_controller.sv
// Sequencer feeding the matrix ALU from a shared registered byte memory:
// fetches A (and B), runs the ALU, writes C back, reports status.
//
// state   | meaning
// IDLE    | waiting for start, instr captured on accept
// LOAD_A  | streaming A reads, capture lags address by one cycle
// LOAD_B  | same for B, binary opcodes only
// EXEC    | operands held on the ALU, result captured
// STORE   | writing C back to memory
// DONE    | one-cycle completion pulse
module matrix_coproc_controller #(
  parameter int ADDR_W      = 8,
  parameter int A_BASE      = 0,
  parameter int B_BASE      = 25,
  parameter int C_BASE      = 50,
  parameter int DET_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [13:0]       instr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              error,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic [2:0]        alu_opcode,
  output logic [2:0]        alu_matrix_size,
  output logic [199:0]      alu_A_flat,
  output logic [199:0]      alu_B_flat,
  output logic [7:0]        alu_scalar,
  input  logic [199:0]      alu_C_flat,
  input  logic              alu_overflow,
  input  logic              alu_done
);

  localparam int TMR_W = $clog2(DET_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [13:0]        instr_q, instr_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2:0]         r_q, r_d, c_q, c_d;
  logic [4:0]         row_q, row_d;
  logic [4:0]         prev_k_q, prev_k_d;
  logic [199:0]       a_flat_q, a_flat_d, b_flat_q, b_flat_d, c_flat_q, c_flat_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               ovf_q, ovf_d, err_q, err_d;

  logic [2:0] op, n;
  logic [4:0] nn, k_cur;
  logic       need_b, is_det, in_invalid, load_issue, capture, store_end;

  assign op         = instr_q[2:0];
  assign n          = instr_q[5:3];
  assign nn         = {2'b00, n} * {2'b00, n};
  assign k_cur      = {r_q, 2'b00} + {2'b00, r_q} + {2'b00, c_q};
  assign need_b     = (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
  assign is_det     = (op == 3'b111);
  assign in_invalid = (instr[2:0] == 3'b000) || (instr[5:3] < 3'd2) || (instr[5:3] > 3'd5);
  assign load_issue = (cnt_q != nn);
  assign capture    = !is_det || alu_done;
  assign store_end  = is_det || (cnt_q == nn - 5'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = in_invalid ? S_DONE : S_LOAD_A;
      S_LOAD_A: if (!load_issue) state_d = need_b ? S_LOAD_B : S_EXEC;
      S_LOAD_B: if (!load_issue) state_d = S_EXEC;
      S_EXEC: begin
        if (capture)           state_d = S_STORE;
        else if (tmr_q == '0)  state_d = S_DONE;
      end
      S_STORE:  if (store_end) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q  <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      c_q      <= '0;
      row_q    <= '0;
      prev_k_q <= '0;
      a_flat_q <= '0;
      b_flat_q <= '0;
      c_flat_q <= '0;
      tmr_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      c_q      <= c_d;
      row_q    <= row_d;
      prev_k_q <= prev_k_d;
      a_flat_q <= a_flat_d;
      b_flat_q <= b_flat_d;
      c_flat_q <= c_flat_d;
      tmr_q    <= tmr_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    c_d      = c_q;
    row_d    = row_q;
    prev_k_d = prev_k_q;
    a_flat_d = a_flat_q;
    b_flat_d = b_flat_q;
    c_flat_d = c_flat_q;
    tmr_d    = tmr_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          instr_d  = instr;
          a_flat_d = '0;
          b_flat_d = '0;
          c_flat_d = '0;
          ovf_d    = 1'b0;
          err_d    = in_invalid;
          cnt_d    = '0;
          r_d      = '0;
          c_d      = '0;
          row_d    = '0;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        // registered memory: data for the previous cycle's address arrives now
        if (cnt_q != '0) begin
          if (state_q == S_LOAD_A) a_flat_d[{prev_k_q, 3'b000} +: 8] = mem_rdata;
          else                     b_flat_d[{prev_k_q, 3'b000} +: 8] = mem_rdata;
        end
        if (load_issue) begin
          prev_k_d = k_cur;
          cnt_d    = cnt_q + 5'd1;
          if (c_q == n - 3'd1) begin
            c_d   = '0;
            r_d   = r_q + 3'd1;
            row_d = row_q + {2'b00, n};
          end else begin
            c_d = c_q + 3'd1;
          end
        end else begin
          cnt_d = '0;
          r_d   = '0;
          c_d   = '0;
          row_d = '0;
          tmr_d = TMR_W'(DET_TIMEOUT - 1);
        end
      end
      S_EXEC: begin
        if (capture) begin
          c_flat_d = alu_C_flat;
          ovf_d    = alu_overflow;
        end else if (tmr_q == '0) begin
          err_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_STORE: begin
        cnt_d = cnt_q + 5'd1;
        if (c_q == n - 3'd1) begin
          c_d   = '0;
          r_d   = r_q + 3'd1;
          row_d = row_q + {2'b00, n};
        end else begin
          c_d = c_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    alu_opcode = '0;
    case (state_q)
      S_LOAD_A: begin
        busy = 1'b1;
        if (load_issue) mem_addr = ADDR_W'(A_BASE) + ADDR_W'(row_q) + ADDR_W'(c_q);
      end
      S_LOAD_B: begin
        busy = 1'b1;
        if (load_issue) mem_addr = ADDR_W'(B_BASE) + ADDR_W'(row_q) + ADDR_W'(c_q);
      end
      S_EXEC: begin
        busy       = 1'b1;
        alu_opcode = op;
      end
      S_STORE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(C_BASE) + ADDR_W'(row_q) + ADDR_W'(c_q);
        mem_wdata = c_flat_q[{k_cur, 3'b000} +: 8];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign overflow        = ovf_q;
  assign error           = err_q;
  assign alu_matrix_size = instr_q[5:3];
  assign alu_scalar      = instr_q[13:6];
  assign alu_A_flat      = a_flat_q;
  assign alu_B_flat      = b_flat_q;

endmodule

// File: tb/tb_matrix_coproc_controller.sv
// Directed bench for matrix_coproc_controller with a registered byte memory
// and a small behavioural ALU (add, scalar multiply, transpose, determinant stub).
module tb_matrix_coproc_controller;

  logic         clock = 1'b0;
  logic         reset, start;
  logic [13:0]  instr;
  logic         busy, done, overflow, error;
  logic [7:0]   mem_addr, mem_rdata, mem_wdata;
  logic         mem_we;
  logic [2:0]   alu_opcode, alu_matrix_size;
  logic [199:0] alu_A_flat, alu_B_flat, alu_C_flat;
  logic [7:0]   alu_scalar;
  logic         alu_overflow, alu_done;

  logic [7:0]   mem [0:255];
  logic         tb_wr;
  logic [7:0]   tb_addr, tb_wdata;
  int           we_cnt = 0, bread_cnt = 0, exec_cnt = 0;
  logic         det_en;
  logic [7:0]   det_val;

  int checks = 0, errors = 0;

  matrix_coproc_controller dut (
    .clock(clock), .reset(reset), .start(start), .instr(instr),
    .busy(busy), .done(done), .overflow(overflow), .error(error),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .alu_opcode(alu_opcode), .alu_matrix_size(alu_matrix_size),
    .alu_A_flat(alu_A_flat), .alu_B_flat(alu_B_flat), .alu_scalar(alu_scalar),
    .alu_C_flat(alu_C_flat), .alu_overflow(alu_overflow), .alu_done(alu_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tb_wr) mem[tb_addr] <= tb_wdata;
    mem_rdata <= mem[mem_addr];
    if (mem_we) we_cnt <= we_cnt + 1;
    if (!mem_we && mem_addr >= 8'd25 && mem_addr <= 8'd49) bread_cnt <= bread_cnt + 1;
    exec_cnt <= (alu_opcode == 3'b111) ? exec_cnt + 1 : 0;
  end

  assign alu_done = det_en && (alu_opcode == 3'b111) && (exec_cnt == 4);

  always_comb begin
    alu_C_flat   = '0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      3'b001: for (int k = 0; k < 25; k++) begin
        alu_C_flat[8*k +: 8] = alu_A_flat[8*k +: 8] + alu_B_flat[8*k +: 8];
        if (int'($signed(alu_A_flat[8*k +: 8])) + int'($signed(alu_B_flat[8*k +: 8])) > 127 ||
            int'($signed(alu_A_flat[8*k +: 8])) + int'($signed(alu_B_flat[8*k +: 8])) < -128)
          alu_overflow = 1'b1;
      end
      3'b100: for (int k = 0; k < 25; k++)
        alu_C_flat[8*k +: 8] = 8'(alu_A_flat[8*k +: 8] * alu_scalar);
      3'b101: for (int k = 0; k < 25; k++)
        alu_C_flat[8*k +: 8] = alu_A_flat[8*(5*(k%5) + k/5) +: 8];
      3'b111: alu_C_flat[7:0] = det_val;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] mk(input logic [2:0] op, input logic [2:0] n, input logic [7:0] s);
    return {s, n, op};
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_addr = a; tb_wdata = d; tb_wr = 1'b1;
    @(posedge clock); #1;
    tb_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clock);
    while ((busy === 1'b1 || done === 1'b1) && g < 500) begin
      @(negedge clock); g++;
    end
  endtask

  // lat_o counts edges after the accepting edge until done is seen high
  task automatic run(input logic [13:0] ins, input int limit, input int intrude_at,
                     output int lat_o, output logic busy_o, output logic ovf_o, output logic err_o);
    wait_idle();
    instr = ins; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    busy_o = busy; ovf_o = overflow; err_o = error; lat_o = 0;
    while (done !== 1'b1 && lat_o < limit) begin
      @(posedge clock); #1;
      lat_o++;
      if (lat_o == intrude_at) begin instr = 14'h0; start = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
  endtask

  int lat, we0, br0, n_wait;
  logic bsy, ovf_a, err_a;
  logic [199:0] obs_v, exp_v;
  logic [13:0] bad [3];

  initial begin
    reset = 1'b1; start = 1'b0; instr = '0; tb_wr = 1'b0; tb_addr = '0; tb_wdata = '0;
    det_en = 1'b0; det_val = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 100; i++) poke(8'(i), 8'h00);
    check("reset_outputs", 200'({busy, done, overflow, error, mem_we, mem_addr, mem_wdata,
                                  alu_opcode, alu_matrix_size, alu_scalar}), '0);
    check("reset_flats", alu_A_flat | alu_B_flat, '0);
    @(negedge clock); reset = 1'b0;

    // sum N=2
    for (int i = 0; i < 4; i++) begin poke(8'(i), 8'(i + 1)); poke(8'(25 + i), 8'(10 * (i + 1))); end
    we0 = we_cnt; br0 = bread_cnt;
    run(mk(3'b001, 3'd2, 8'd0), 30, -1, lat, bsy, ovf_a, err_a);
    check("sum_latency", 200'(lat), 200'(15));
    check("sum_busy", 200'(bsy), 200'(1));
    check("sum_result", 200'({mem[53], mem[52], mem[51], mem[50]}), 200'(32'h2c21160b));
    check("sum_writes", 200'(we_cnt - we0), 200'(4));
    check("sum_b_reads", 200'(bread_cnt - br0), 200'(4));
    check("sum_flags", 200'({overflow, error}), 200'(0));

    // scalar N=3, scalar 2, with an ignored start mid-run
    for (int i = 0; i < 9; i++) poke(8'(i), 8'(i + 1));
    we0 = we_cnt; br0 = bread_cnt;
    run(mk(3'b100, 3'd3, 8'd2), 40, 5, lat, bsy, ovf_a, err_a);
    check("scalar_latency", 200'(lat), 200'(20));
    obs_v = '0; exp_v = '0;
    for (int i = 0; i < 9; i++) begin obs_v[8*i +: 8] = mem[50 + i]; exp_v[8*i +: 8] = 8'(2 * (i + 1)); end
    check("scalar_result", obs_v, exp_v);
    check("scalar_b_reads", 200'(bread_cnt - br0), 200'(0));
    check("scalar_writes", 200'(we_cnt - we0), 200'(9));
    check("busy_start_ignored", 200'(error), 200'(0));

    // transpose N=5
    for (int i = 0; i < 25; i++) poke(8'(i), 8'(i));
    run(mk(3'b101, 3'd5, 8'd0), 70, -1, lat, bsy, ovf_a, err_a);
    check("transpose_latency", 200'(lat), 200'(52));
    obs_v = '0; exp_v = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        obs_v[8*(5*r + c) +: 8] = mem[50 + 5*r + c];
        exp_v[8*(5*r + c) +: 8] = 8'(5*c + r);
      end
    check("transpose_result", obs_v, exp_v);
    exp_v = '0;
    for (int k = 0; k < 25; k++) exp_v[8*k +: 8] = 8'(k);
    check("transpose_a_flat", alu_A_flat, exp_v);

    // signed overflow 127+1, held until next accept
    poke(8'd0, 8'd127); poke(8'd25, 8'd1);
    for (int i = 1; i < 4; i++) begin poke(8'(i), 8'h00); poke(8'(25 + i), 8'h00); end
    run(mk(3'b001, 3'd2, 8'd0), 30, -1, lat, bsy, ovf_a, err_a);
    check("ovf_set", 200'(overflow), 200'(1));
    check("ovf_result", 200'(mem[50]), 200'(8'h80));
    repeat (3) @(posedge clock);
    #1;
    check("ovf_held", 200'(overflow), 200'(1));
    for (int i = 0; i < 4; i++) begin poke(8'(i), 8'(i + 1)); poke(8'(25 + i), 8'(10 * (i + 1))); end
    run(mk(3'b001, 3'd2, 8'd0), 30, -1, lat, bsy, ovf_a, err_a);
    check("ovf_clear_on_accept", 200'(ovf_a), 200'(0));
    check("ovf_rerun_result", 200'({mem[53], mem[52], mem[51], mem[50]}), 200'(32'h2c21160b));

    // determinant: alu_done after 4 EXEC cycles
    det_val = 8'hFD; det_en = 1'b1;
    we0 = we_cnt;
    run(mk(3'b111, 3'd3, 8'd0), 40, -1, lat, bsy, ovf_a, err_a);
    check("det_latency", 200'(lat), 200'(16));
    check("det_result", 200'(mem[50]), 200'(8'hFD));
    check("det_writes", 200'(we_cnt - we0), 200'(1));
    check("det_error", 200'(error), 200'(0));

    // determinant timeout: 10 load cycles + 255 EXEC cycles, no STORE
    det_en = 1'b0;
    we0 = we_cnt;
    run(mk(3'b111, 3'd3, 8'd0), 300, -1, lat, bsy, ovf_a, err_a);
    check("det_timeout_latency", 200'(lat), 200'(265));
    check("det_timeout_error", 200'(error), 200'(1));
    check("det_timeout_writes", 200'(we_cnt - we0), 200'(0));

    // invalid instructions: done in the very next cycle, no memory traffic
    bad[0] = mk(3'b000, 3'd2, 8'd0);
    bad[1] = mk(3'b001, 3'd1, 8'd0);
    bad[2] = mk(3'b001, 3'd6, 8'd0);
    for (int i = 0; i < 3; i++) begin
      we0 = we_cnt; br0 = bread_cnt;
      run(bad[i], 5, -1, lat, bsy, ovf_a, err_a);
      check($sformatf("invalid%0d_latency", i), 200'(lat), 200'(0));
      check($sformatf("invalid%0d_error", i), 200'({error, bsy}), 200'(2'b10));
      check($sformatf("invalid%0d_mem", i), 200'((we_cnt - we0) + (bread_cnt - br0)), 200'(0));
    end

    // reset in the middle of STORE
    wait_idle();
    instr = mk(3'b101, 3'd5, 8'd0); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("err_clear_on_accept", 200'(error), 200'(0));
    n_wait = 0;
    while (mem_we !== 1'b1 && n_wait < 100) begin @(posedge clock); #1; n_wait++; end
    check("store_start_edge", 200'(n_wait), 200'(27));
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("reset_mid_store", 200'({mem_we, busy, done}), 200'(0));
    check("reset_mid_store_flats", alu_A_flat, '0);
    we0 = we_cnt;
    repeat (3) @(posedge clock);
    #1;
    check("reset_no_more_writes", 200'(we_cnt - we0), 200'(0));
    @(negedge clock); reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("after_reset_idle", 200'({busy, done, mem_we, alu_opcode}), 200'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
